// File: rtl/fabric_tag_route_buffer_if.sv
// fabric_tag_route_buffer_if: tagged input stream plus per-lane output streams
// and error reporting for fabric_tag_route_buffer.
// master = upstream producer / lane consumers, slave = the route buffer.
// Optional FABRIC_TAG_ROUTE_STATS_EN adds the drop_count signal.
interface fabric_tag_route_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int NUM_OUT    = 4
);
   logic                            in_valid;
   logic                            in_ready;
   logic [DATA_WIDTH+TAG_WIDTH-1:0] in_data;
   logic [NUM_OUT-1:0]              out_valid;
   logic [NUM_OUT-1:0]              out_ready;
   logic [NUM_OUT*DATA_WIDTH-1:0]   out_data;
   logic                            err_valid;
   logic [TAG_WIDTH-1:0]            err_tag;
`ifdef FABRIC_TAG_ROUTE_STATS_EN
   logic [15:0]                     drop_count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, err_valid, err_tag, drop_count
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, err_valid, err_tag, drop_count
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, err_valid, err_tag
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, err_valid, err_tag
   );
`endif
endinterface

// File: rtl/fabric_tag_route_buffer.sv
// fabric_tag_route_buffer: routes {tag, payload} beats into per-lane FIFOs
// indexed by tag, strips the tag, and flags out-of-range tags (sticky, first
// tag kept). A stalled lane never blocks the other lanes.
// Optional feature macro: FABRIC_TAG_ROUTE_STATS_EN (saturating drop_count).
module fabric_tag_route_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int NUM_OUT    = 4,
   parameter int DEPTH      = 4
) (
   input logic                      clk,
   input logic                      rst,
   fabric_tag_route_buffer_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]        DEPTH_C   = CW'(DEPTH);
   localparam logic [PW-1:0]        LAST_C    = PW'(DEPTH - 1);
   localparam logic [TAG_WIDTH:0]   NUM_OUT_C = (TAG_WIDTH + 1)'(NUM_OUT);

   generate
      if (DATA_WIDTH < 1) begin : g_bad_data
         $fatal(1, "COMP_TAG_ROUTE_DATA_WIDTH: DATA_WIDTH must be >= 1");
      end
      if (TAG_WIDTH < 1) begin : g_bad_tag
         $fatal(1, "COMP_TAG_ROUTE_TAG_WIDTH: TAG_WIDTH must be >= 1");
      end
      if (NUM_OUT < 1 || NUM_OUT > (1 << TAG_WIDTH)) begin : g_bad_num
         $fatal(1, "COMP_TAG_ROUTE_NUM_OUT: NUM_OUT must be in 1..2**TAG_WIDTH");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $fatal(1, "COMP_TAG_ROUTE_DEPTH: DEPTH must be >= 2");
      end
   endgenerate

   // Pointer advance with explicit wrap, since DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PW'(1);
   endfunction

   // Occupancy update; push and pop together leave the count unchanged.
   function automatic logic [CW-1:0] count_next(input logic [CW-1:0] c,
                                                input logic push_i,
                                                input logic pop_i);
      logic [CW-1:0] n;
      n = c;
      if (push_i && !pop_i)      n = c + CW'(1);
      else if (pop_i && !push_i) n = c - CW'(1);
      return n;
   endfunction

   // Saturating increment for the 16-bit drop counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [TAG_WIDTH-1:0]  tag;
   logic [DATA_WIDTH-1:0] payload;
   logic                  in_range;
   logic                  accept;
   logic [NUM_OUT-1:0]    hit;
   logic [NUM_OUT-1:0]    full;
   logic [NUM_OUT-1:0]    empty;
   logic [NUM_OUT-1:0]    push;
   logic [NUM_OUT-1:0]    pop;
   logic [PW-1:0]         wr_ptr [NUM_OUT];
   logic [PW-1:0]         rd_ptr [NUM_OUT];
   logic [CW-1:0]         count  [NUM_OUT];
   logic [DATA_WIDTH-1:0] mem    [NUM_OUT][DEPTH];
   logic                  err_valid_r;
   logic [TAG_WIDTH-1:0]  err_tag_r;

   assign tag      = bus.in_data[DATA_WIDTH +: TAG_WIDTH];
   assign payload  = bus.in_data[DATA_WIDTH-1:0];
   assign in_range = {1'b0, tag} < NUM_OUT_C;

   // Decode the target lane and per-lane full/empty flags from the counts.
   always_comb begin
      hit   = '0;
      full  = '0;
      empty = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         hit[i]   = in_range && (tag == TAG_WIDTH'(i));
         full[i]  = (count[i] == DEPTH_C);
         empty[i] = (count[i] == '0);
      end
   end

   // Error beats are always ready (discarded); in-range beats wait on their lane only.
   assign bus.in_ready  = !rst && !(|(hit & full));
   assign accept        = bus.in_valid && bus.in_ready;
   assign push          = {NUM_OUT{accept}} & hit;
   assign bus.out_valid = ~empty;
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.err_valid = err_valid_r;
   assign bus.err_tag   = err_tag_r;

   // Head entry of each lane drives its output slice straight from storage.
   always_comb begin
      bus.out_data = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
      end
   end

   // Per-lane pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (push[i]) wr_ptr[i] <= ptr_next(wr_ptr[i]);
            if (pop[i])  rd_ptr[i] <= ptr_next(rd_ptr[i]);
            count[i] <= count_next(count[i], push[i], pop[i]);
         end
      end
   end

   // Payload storage; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_OUT; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= payload;
      end
   end

   // Sticky capture of the first out-of-range tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_valid_r <= 1'b0;
         err_tag_r   <= '0;
      end else if (accept && !in_range && !err_valid_r) begin
         err_valid_r <= 1'b1;
         err_tag_r   <= tag;
      end
   end

`ifdef FABRIC_TAG_ROUTE_STATS_EN
   logic [15:0] drop_count_r;

   assign bus.drop_count = drop_count_r;

   // Saturating count of discarded error beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     drop_count_r <= '0;
      else if (accept && !in_range) drop_count_r <= sat_inc16(drop_count_r);
   end
`else
   // Drop statistics are not built in this configuration.
   always_comb begin
      if (1'b0) begin
         void'(sat_inc16(16'd0));
      end
   end
`endif
endmodule

// File: tb/tb_fabric_tag_route_buffer.sv
// tb_fabric_tag_route_buffer: directed test of routing, backpressure isolation,
// FIFO wrap with simultaneous push/pop, error capture, reset and (when
// FABRIC_TAG_ROUTE_STATS_EN is defined) drop counter saturation.
module tb_fabric_tag_route_buffer;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int NO = 4;
   localparam int DP = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;
   int   tx;
   int   rx;

   fabric_tag_route_buffer_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_OUT(NO)) bus ();

   fabric_tag_route_buffer #(
      .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_OUT(NO), .DEPTH(DP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs.
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
      else n_pass++;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for exactly one edge (caller ensures it is accepted).
   task automatic push_beat(input logic [TW-1:0] t, input logic [DW-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = {t, d};
      step();
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [DW-1:0] lane(input int i);
      return bus.out_data[i*DW +: DW];
   endfunction

   initial begin
      n_chk  = 0;
      n_pass = 0;

      // Reset with a valid beat for lane 0 pending
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = {4'd0, 32'h0};
      bus.out_ready = '0;
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_err_valid", bus.err_valid, 0);
      chk("rst_err_tag", bus.err_tag, 0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      step();

      // Single route to lane 2, then pop it
      push_beat(4'd2, 32'hDEADBEEF);
      chk("route_valid", bus.out_valid, 4'b0100);
      chk("route_data", lane(2), 32'hDEADBEEF);
      bus.out_ready = 4'b0100;
      step();
      bus.out_ready = '0;
      chk("route_pop_valid", bus.out_valid, 0);

      // Backpressure isolation: fill lane 1, lane 3 still flows
      for (int k = 0; k < 4; k++) push_beat(4'd1, 32'(100 + k));
      bus.in_data = {4'd1, 32'd999};
      #1;
      chk("bp_lane1_full_ready", bus.in_ready, 0);
      bus.in_data = {4'd3, 32'h333};
      #1;
      chk("bp_lane3_ready", bus.in_ready, 1);
      push_beat(4'd3, 32'h333);
      chk("bp_valid", bus.out_valid, 4'b1010);
      chk("bp_lane3_data", lane(3), 32'h333);
      bus.out_ready = 4'b1010;
      bus.in_data   = {4'd1, 32'd0};
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_lane1_order", lane(1), 32'(100 + k));
         chk("bp_lane1_ready", bus.in_ready, (k == 0) ? 1'b0 : 1'b1);
         step();
      end
      bus.out_ready = '0;
      chk("bp_drained", bus.out_valid, 0);

      // Same-cycle push and pop at count 2 on lane 0
      push_beat(4'd0, 32'hA0);
      push_beat(4'd0, 32'hB0);
      bus.out_ready = 4'b0001;
      push_beat(4'd0, 32'hC0);
      bus.out_ready = '0;
      chk("pp_head", lane(0), 32'hB0);
      push_beat(4'd0, 32'hD0);
      bus.in_data = {4'd0, 32'hE0};
      #1;
      chk("pp_count3_ready", bus.in_ready, 1);
      push_beat(4'd0, 32'hE0);
      bus.out_ready = 4'b0001;
      bus.in_data   = {4'd0, 32'hF0};
      #1;
      chk("pp_full_no_bypass", bus.in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         chk("pp_drain", lane(0), 32'hB0 + 32'(k * 16));
         step();
      end
      bus.out_ready = '0;
      chk("pp_empty", bus.out_valid, 0);

      // Ten beats through lane 0 with out_ready toggling
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 80 && rx < 10; cyc++) begin
         bus.out_ready = {3'b000, cyc[0]};
         bus.in_valid  = (tx < 10);
         bus.in_data   = {4'd0, 32'(tx)};
         #1;
         if (bus.out_valid[0] && bus.out_ready[0]) begin
            chk("wrap_order", lane(0), 32'(rx));
            rx++;
         end
         if (bus.in_valid && bus.in_ready) tx++;
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = '0;
      chk("wrap_rx_count", rx, 10);
      chk("wrap_empty", bus.out_valid, 0);

      // Out-of-range tags: first one is captured and held
      bus.in_data = {4'd5, 32'h55};
      #1;
      chk("err5_ready", bus.in_ready, 1);
      push_beat(4'd5, 32'h55);
      chk("err5_no_lane", bus.out_valid, 0);
      chk("err5_valid", bus.err_valid, 1);
      chk("err5_tag", bus.err_tag, 5);
      bus.in_data = {4'd7, 32'h77};
      #1;
      chk("err7_ready", bus.in_ready, 1);
      push_beat(4'd7, 32'h77);
      chk("err7_no_lane", bus.out_valid, 0);
      chk("err7_tag_held", bus.err_tag, 5);

`ifdef FABRIC_TAG_ROUTE_STATS_EN
      push_beat(4'd9, 32'h99);
      chk("stats_three", bus.drop_count, 3);
      bus.in_valid = 1'b1;
      bus.in_data  = {4'd15, 32'h0};
      for (int k = 0; k < 65540; k++) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("stats_saturated", bus.drop_count, 16'hFFFF);
      step();
      chk("stats_hold", bus.drop_count, 16'hFFFF);
`endif

      // Reset in the middle of buffered traffic
      push_beat(4'd3, 32'h1234);
      chk("midrst_before", bus.out_valid, 4'b1000);
      bus.in_valid = 1'b1;
      bus.in_data  = {4'd0, 32'h0};
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      chk("midrst_err_valid", bus.err_valid, 0);
      chk("midrst_err_tag", bus.err_tag, 0);
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("midrst_after_ready", bus.in_ready, 1);
      chk("midrst_after_valid", bus.out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
